pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It sits beside the decode stage and watches the register sources of the decoding instruction against the destinations of the downstream stages. It produces per-read-port forwarding selects, fetch/decode stall, execute bubble and decode flush. It also owns a latency tracker for the multi-cycle multiply/divide unit (MDU) and a saturating stall-cycle performance counter.

Parameters:
NREAD, 2, number of decode register read ports
NSTAGE, 3, downstream producer stages; index 0 = EX, 1 = MEM, 2 = WB (nearest first)
REG_AW, 5, register address width
MDU_LAT, 4, MDU cycles from issue to result (>=1)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
d_valid  in  1  decode holds a valid instruction
d_src  in  NREAD x REG_AW  source register per port
d_src_used  in  NREAD  port actually read
d_is_branch  in  1  instruction resolves a branch/jump-register in decode
d_mdu_start  in  1  instruction issues an MDU operation
d_mdu_read  in  1  instruction reads the MDU result (mfhi/mflo)
br_taken  in  1  decode computed a taken redirect
s_dst  in  NSTAGE x REG_AW  destination register per stage
s_we  in  NSTAGE  stage will write s_dst
s_rdy  in  NSTAGE  stage's result value is available now (0 for a load in EX)
fwd_sel  out  NREAD x $clog2(NSTAGE+1)  0 = regfile, k+1 = forward from stage k
stall_f  out  1  hold PC
stall_d  out  1  hold f_d register
bubble_e  out  1  insert NOP into d_e register
flush_d  out  1  squash f_d register
mdu_busy  out  1  MDU operation in flight
mdu_done  out  1  MDU result valid this cycle
stall_cnt  out  CNT_W  stall cycles since reset

Behaviour:
- Match rule, per port p: consider p only if d_valid, d_src_used[p] and d_src[p]!=0. Take the smallest k with s_we[k] && s_dst[k]==d_src[p]. Nearest stage wins. Register 0 is never forwarded.
- No match: fwd_sel[p]=0.
- Match with s_rdy[k]=1: fwd_sel[p]=k+1.
- Match with s_rdy[k]=0: data stall (load-use); fwd_sel[p]=0.
- Branch rule: if d_is_branch and the winning match is k=0, data stall regardless of s_rdy. Decode cannot take the EX-stage result in the same cycle.
- MDU FSM: states IDLE, BUSY, DONE, with down-counter cnt of width $clog2(MDU_LAT+1).
  - IDLE: on d_valid && d_mdu_start && !stall, go to BUSY with cnt=MDU_LAT-1, or go straight to DONE if MDU_LAT==1.
  - BUSY: cnt decrements each cycle; when cnt==0, next state is DONE.
  - DONE lasts one cycle with mdu_done=1. It returns to IDLE, or back to BUSY if a new unstalled start is accepted that cycle.
  - mdu_busy=1 exactly in BUSY.
- MDU stall: d_valid && (d_mdu_start || d_mdu_read) while in BUSY. No MDU stall in IDLE or DONE.
- stall = data stall | MDU stall. stall_f = stall_d = bubble_e = stall.
- flush_d = br_taken && !stall. A stall suppresses the redirect, and the branch re-resolves when the stall clears.
- d_valid=0: stall=0, all fwd_sel=0, no MDU issue.
- All outputs other than the registered state are combinational, zero latency.
- stall_cnt increments by 1 on every cycle with stall=1 and saturates at all-ones.
- Reset (reset==0 at the edge): FSM=IDLE, cnt=0, stall_cnt=0. While reset is low, all outputs are forced to 0. Reset during BUSY aborts the operation and no mdu_done is produced.

Decomposition:
- pipes package gains: fwd_sel_t (width $clog2(NSTAGE+1)), the mdu_state_t enum {IDLE, BUSY, DONE}, and stage-index constants STG_EX=0, STG_MEM=1, STG_WB=2.
- Sub-module mdu_tracker (FSM + counter; ports clk, reset, issue, busy, done) is the natural split.
- Match/priority logic stays as a generate loop over NREAD.

Test Plan:
- Load-use: d_src={8,0}, used=01; s_dst[0]=8, s_we=001, s_rdy=000 -> stall_f=stall_d=bubble_e=1, fwd_sel[0]=0. Next cycle same register moves to MEM with s_rdy[1]=1 -> stall=0, fwd_sel[0]=2.
- Priority: d_src[1]=9 matches EX (rdy) and WB -> fwd_sel[1]=1. Same test with d_src[1]=0 -> fwd_sel[1]=0 and no stall.
- Branch: d_is_branch=1, d_src[0]=4 matches EX rdy=1 with br_taken=1 -> stall=1, flush_d=0. Next cycle, match in MEM -> fwd_sel[0]=2, flush_d=1.
- MDU, MDU_LAT=4: start at cycle 0 -> mdu_busy=1 in cycles 1-3, mdu_done=1 in cycle 4. An mflo presented at cycle 1 stalls cycles 1-3 and proceeds at cycle 4. Back-to-back start in DONE is accepted.
- Reset: drive reset=0 during BUSY -> mdu_busy=0, stall_cnt=0 after the edge, no mdu_done. Also force stall for 2^CNT_W+2 cycles with CNT_W=4 -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the decode-side hazard/forwarding controller.
package pipe_hazard_unit_pkg;
  localparam int NSTAGE_DEF = 3;
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef logic [$clog2(NSTAGE_DEF+1)-1:0] fwd_sel_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Decode/stage view exchanged between the pipeline (master) and the hazard unit (slave).
interface pipe_hazard_unit_if #(
  parameter int NREAD  = 2,
  parameter int NSTAGE = 3,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  localparam int SW = $clog2(NSTAGE+1);

  logic                           d_valid;
  logic [NREAD-1:0][REG_AW-1:0]   d_src;
  logic [NREAD-1:0]               d_src_used;
  logic                           d_is_branch;
  logic                           d_mdu_start;
  logic                           d_mdu_read;
  logic                           br_taken;
  logic [NSTAGE-1:0][REG_AW-1:0]  s_dst;
  logic [NSTAGE-1:0]              s_we;
  logic [NSTAGE-1:0]              s_rdy;
  logic [NREAD-1:0][SW-1:0]       fwd_sel;
  logic                           stall_f;
  logic                           stall_d;
  logic                           bubble_e;
  logic                           flush_d;
  logic                           mdu_busy;
  logic                           mdu_done;
  logic [CNT_W-1:0]               stall_cnt;

  modport master (
    output d_valid, d_src, d_src_used, d_is_branch, d_mdu_start, d_mdu_read, br_taken,
           s_dst, s_we, s_rdy,
    input  fwd_sel, stall_f, stall_d, bubble_e, flush_d, mdu_busy, mdu_done, stall_cnt
  );

  modport slave (
    input  d_valid, d_src, d_src_used, d_is_branch, d_mdu_start, d_mdu_read, br_taken,
           s_dst, s_we, s_rdy,
    output fwd_sel, stall_f, stall_d, bubble_e, flush_d, mdu_busy, mdu_done, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit_mdu_tracker.sv
// Tracks one in-flight multiply/divide: BUSY for MDU_LAT-1 cycles, then a one-cycle DONE.
module pipe_hazard_unit_mdu_tracker
  import pipe_hazard_unit_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(MDU_LAT+1);
  localparam logic [1:0] S_IDLE = MDU_IDLE;
  localparam logic [1:0] S_BUSY = MDU_BUSY;
  localparam logic [1:0] S_DONE = MDU_DONE;
  localparam logic [CW-1:0] LOAD = CW'(MDU_LAT-1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (issue) begin
            cnt   <= LOAD;
            state <= (MDU_LAT == 1) ? S_DONE : S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          // Leave BUSY on the cycle the count reaches zero.
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);
endmodule

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard detection, forwarding select, MDU interlock and stall counter.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int NREAD   = 2,
  parameter int NSTAGE  = 3,
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  pipe_hazard_unit_if.slave hz
);
  localparam int SW = $clog2(NSTAGE+1);

  logic [NREAD-1:0]         port_stall;
  logic [NREAD-1:0][SW-1:0] fwd;
  logic                     mdu_busy, mdu_done, mdu_stall, stall, issue;
  logic [CNT_W-1:0]         stall_q;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic          any, hit, rdy, is_ex;
    logic [SW-1:0] sel;

    // Walk farthest to nearest so the nearest matching stage is what remains.
    always_comb begin
      any   = 1'b0;
      rdy   = 1'b0;
      is_ex = 1'b0;
      sel   = '0;
      for (int k = NSTAGE-1; k >= 0; k--) begin
        if (hz.s_we[k] && hz.s_dst[k] == hz.d_src[p]) begin
          any   = 1'b1;
          rdy   = hz.s_rdy[k];
          is_ex = (k == STG_EX);
          sel   = SW'(k+1);
        end
      end
    end

    assign hit           = any && hz.d_valid && hz.d_src_used[p] && (hz.d_src[p] != '0);
    assign port_stall[p] = hit && (!rdy || (hz.d_is_branch && is_ex));
    assign fwd[p]        = (hit && !port_stall[p]) ? sel : '0;
  end

  assign mdu_stall = hz.d_valid && (hz.d_mdu_start || hz.d_mdu_read) && mdu_busy;
  assign stall     = (|port_stall) || mdu_stall;
  assign issue     = hz.d_valid && hz.d_mdu_start && !stall;

  pipe_hazard_unit_mdu_tracker #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .issue (issue),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  always_ff @(posedge clk) begin
    if (!reset)                    stall_q <= '0;
    else if (stall && ~&stall_q)   stall_q <= stall_q + 1'b1;
  end

  // Everything is held quiet while reset is asserted.
  assign hz.fwd_sel   = reset ? fwd : '0;
  assign hz.stall_f   = reset && stall;
  assign hz.stall_d   = reset && stall;
  assign hz.bubble_e  = reset && stall;
  assign hz.flush_d   = reset && hz.br_taken && !stall;
  assign hz.mdu_busy  = reset && mdu_busy;
  assign hz.mdu_done  = reset && mdu_done;
  assign hz.stall_cnt = reset ? stall_q : '0;
endmodule
